m68k_bus_initiator: RTL and testbench
=====================================

// Module: m68k_bus_initiator
// PURPOSE
//  68000-style asynchronous bus master. It turns single-beat requests from an internal
//  client (DMA engine, debug loader) into AS_n/UDS_n/LDS_n/RW bus cycles and waits for
//  DTACK_n from the address decoder and slaves.
//  A cycle with no DTACK_n within TIMEOUT clocks ends with an error response
//  (software bus error). Misaligned word requests are rejected without a bus cycle.
// PARAMETERS
//  TIMEOUT   64  max clocks in WAIT before bus error; also max clocks in REC (>=4)
//  CNT_W     8   width of timeout counter; must hold TIMEOUT
// PORTS
//  i_CLK          in   1   system clock
//  i_RESET_n      in   1   asynchronous, active-low reset
//  i_REQ          in   1   request valid
//  o_REQ_READY    out  1   high only in IDLE; transfer = i_REQ & o_REQ_READY at i_CLK rise
//  i_REQ_ADDR     in   24  byte address; bit0 selects byte lane
//  i_REQ_WR       in   1   1=write, 0=read
//  i_REQ_BYTE     in   1   1=byte access, 0=word access
//  i_REQ_WDATA    in   16  write data; byte writes use [15:8] if A0=0, [7:0] if A0=1
//  o_RSP_VALID    out  1   one-cycle pulse, cycle complete
//  o_RSP_ERR      out  1   qualified by o_RSP_VALID; 1=timeout or misaligned
//  o_RSP_RDATA    out  16  read data captured from i_D; held until next response
//  o_A            out  23  bus address A23..A1
//  o_AS_n         out  1   address strobe
//  o_UDS_n        out  1   upper data strobe (D15..8, even byte)
//  o_LDS_n        out  1   lower data strobe (D7..0, odd byte)
//  o_RW           out  1   1=read, 0=write
//  o_D            out  16  write data to bus
//  o_D_OE         out  1   data bus output enable
//  i_D            in   16  read data from bus
//  i_DTACK_n      in   1   async acknowledge; 2-flop synchronised inside (sync resets to 1)
// BEHAVIOUR
//  - Reset values: o_AS_n=o_UDS_n=o_LDS_n=1, o_RW=1, o_D_OE=0, o_A=0, o_D=0,
//    o_RSP_VALID=0, o_RSP_ERR=0, o_RSP_RDATA=0, state=IDLE. All outputs are registered.
//  - The request is latched on accept. Inputs are ignored while not in IDLE.
//  - Lane select: byte access, A0=0 -> UDS; byte access, A0=1 -> LDS; word -> both.
//  - Misaligned request (word, A0=1): IDLE->REL, no strobes, o_RSP_VALID=1 with
//    o_RSP_ERR=1 one clock after accept.
//  - IDLE : ready=1; on accept -> ADDR.
//  - ADDR : o_A and o_RW driven. Write: o_D driven, o_D_OE=1. -> STRB.
//  - STRB : o_AS_n=0. Read: the selected DS_n go 0 here.
//           -> WAIT (read) or -> WDS (write).
//  - WDS  : write only; the selected DS_n go 0 (data stable one clock before DS). -> WAIT.
//  - WAIT : counter increments each clock.
//           Synchronised DTACK=0 -> REL, capturing i_D into o_RSP_RDATA (reads), ERR=0.
//           Counter==TIMEOUT-1 without DTACK -> REL with ERR=1; o_RSP_RDATA unchanged.
//  - REL  : AS_n, DS_n = 1; o_D_OE=0; o_RSP_VALID=1 for this cycle only; o_RW held. -> REC.
//  - REC  : o_RW returns to 1. Wait for synchronised DTACK=1 -> IDLE.
//           After TIMEOUT clocks, -> IDLE regardless (stuck DTACK must not hang the master).
//  - The counter clears on entry to WAIT and to REC.
//  - AS_n is never low while the state is IDLE, ADDR or REC. DS_n is never low while
//    AS_n is high.
//  - Async reset mid-cycle: all strobes go inactive immediately, with no response.
//  - Back-to-back: the earliest next accept is the first IDLE cycle after REC;
//    AS_n is high for at least 2 clocks between cycles.
// TESTING
//  1. Word read 0x000100, DTACK_n low before accept, released when AS_n rises
//     -> AS_n/UDS_n/LDS_n low together; o_RSP_VALID 3 clocks after accept;
//        RDATA = i_D = 0xBEEF; ERR=0.
//  2. Byte write 0x000101, data 0x0055
//     -> o_D_OE up at ADDR; AS_n low at STRB; only LDS_n low, and 1 clock after AS_n;
//        UDS_n stays 1; RW=0 throughout the strobe; ERR=0.
//  3. Read with DTACK_n never asserted, TIMEOUT=16
//     -> strobes released after 16 WAIT clocks; VALID with ERR=1; RDATA keeps its
//        prior value; returns to IDLE.
//  4. Word read at 0x000003 -> no strobe activity; VALID+ERR one clock after accept.
//  5. DTACK_n held low after the cycle -> REC lasts TIMEOUT clocks, then READY=1;
//     the next request runs normally.
//  6. Assert i_RESET_n=0 during WAIT -> strobes go 1 asynchronously; no VALID;
//     READY=1 after reset release.

Source files
------------

// File: rtl/m68k_bus_initiator_if.sv
// Client request/response and 68000-style bus signals grouped for the bus initiator.
interface m68k_bus_initiator_if;
  // Client side
  logic        i_REQ;
  logic        o_REQ_READY;
  logic [23:0] i_REQ_ADDR;
  logic        i_REQ_WR;
  logic        i_REQ_BYTE;
  logic [15:0] i_REQ_WDATA;
  logic        o_RSP_VALID;
  logic        o_RSP_ERR;
  logic [15:0] o_RSP_RDATA;
  // Bus side
  logic [22:0] o_A;
  logic        o_AS_n;
  logic        o_UDS_n;
  logic        o_LDS_n;
  logic        o_RW;
  logic [15:0] o_D;
  logic        o_D_OE;
  logic [15:0] i_D;
  logic        i_DTACK_n;

  // The initiator itself
  modport master (
    input  i_REQ, i_REQ_ADDR, i_REQ_WR, i_REQ_BYTE, i_REQ_WDATA, i_D, i_DTACK_n,
    output o_REQ_READY, o_RSP_VALID, o_RSP_ERR, o_RSP_RDATA,
           o_A, o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D, o_D_OE
  );

  // Client plus decoder/slaves as seen from outside
  modport slave (
    output i_REQ, i_REQ_ADDR, i_REQ_WR, i_REQ_BYTE, i_REQ_WDATA, i_D, i_DTACK_n,
    input  o_REQ_READY, o_RSP_VALID, o_RSP_ERR, o_RSP_RDATA,
           o_A, o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D, o_D_OE
  );
endinterface

// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus master: turns single-beat client requests into
// AS_n/UDS_n/LDS_n/RW cycles, waits for DTACK_n, and times out stuck cycles.
module m68k_bus_initiator #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_n,
  m68k_bus_initiator_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StStrb, StWds, StWait, StRel, StRec
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [15:0]      rsp_rdata_q;
  logic [22:0]      a_q;
  logic             as_n_q;
  logic             uds_n_q;
  logic             lds_n_q;
  logic             rw_q;
  logic [15:0]      d_q;
  logic             d_oe_q;
  logic             uds_sel_q;
  logic             lds_sel_q;
  logic             dtack_s1_q;
  logic             dtack_s2_q;

  // Two-flop synchroniser for the asynchronous acknowledge; idles deasserted.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      dtack_s1_q <= 1'b1;
      dtack_s2_q <= 1'b1;
    end else begin
      dtack_s1_q <= bus.i_DTACK_n;
      dtack_s2_q <= dtack_s1_q;
    end
  end

  // Bus cycle sequencer; every bus and response output is registered here.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      a_q         <= '0;
      as_n_q      <= 1'b1;
      uds_n_q     <= 1'b1;
      lds_n_q     <= 1'b1;
      rw_q        <= 1'b1;
      d_q         <= '0;
      d_oe_q      <= 1'b0;
      uds_sel_q   <= 1'b0;
      lds_sel_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_REQ) begin
            ready_q <= 1'b0;
            if (!bus.i_REQ_BYTE && bus.i_REQ_ADDR[0]) begin
              // Odd word address: answer with an error, never touch the bus.
              state_q     <= StRel;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q   <= StAddr;
              a_q       <= bus.i_REQ_ADDR[23:1];
              rw_q      <= ~bus.i_REQ_WR;
              d_oe_q    <= bus.i_REQ_WR;
              if (bus.i_REQ_WR) begin
                d_q <= bus.i_REQ_WDATA;
              end
              uds_sel_q <= bus.i_REQ_BYTE ? ~bus.i_REQ_ADDR[0] : 1'b1;
              lds_sel_q <= bus.i_REQ_BYTE ?  bus.i_REQ_ADDR[0] : 1'b1;
            end
          end
        end
        StAddr: begin
          as_n_q <= 1'b0;
          if (rw_q) begin
            // Reads drop the data strobes together with AS_n.
            uds_n_q <= ~uds_sel_q;
            lds_n_q <= ~lds_sel_q;
          end
          state_q <= StStrb;
        end
        StStrb: begin
          if (rw_q) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end else begin
            // Writes hold data one clock before the data strobes.
            uds_n_q <= ~uds_sel_q;
            lds_n_q <= ~lds_sel_q;
            state_q <= StWds;
          end
        end
        StWds: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          if (!dtack_s2_q || cnt_q == CntLast) begin
            state_q     <= StRel;
            as_n_q      <= 1'b1;
            uds_n_q     <= 1'b1;
            lds_n_q     <= 1'b1;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= dtack_s2_q;
            if (!dtack_s2_q && rw_q) begin
              rsp_rdata_q <= bus.i_D;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRel: begin
          state_q <= StRec;
          rw_q    <= 1'b1;
          cnt_q   <= '0;
        end
        StRec: begin
          // Leave once the slave lets go of DTACK_n, or give up on a stuck one.
          if (dtack_s2_q || cnt_q == CntLast) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_REQ_READY = ready_q;
  assign bus.o_RSP_VALID = rsp_valid_q;
  assign bus.o_RSP_ERR   = rsp_err_q;
  assign bus.o_RSP_RDATA = rsp_rdata_q;
  assign bus.o_A         = a_q;
  assign bus.o_AS_n      = as_n_q;
  assign bus.o_UDS_n     = uds_n_q;
  assign bus.o_LDS_n     = lds_n_q;
  assign bus.o_RW        = rw_q;
  assign bus.o_D         = d_q;
  assign bus.o_D_OE      = d_oe_q;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Randomised bench for m68k_bus_initiator with a transaction-level timing model.
module tb_m68k_bus_initiator;

  localparam int unsigned Timeout = 16;
  localparam int DtPre   = 0;  // DTACK_n low before the request
  localparam int DtDelay = 1;  // DTACK_n low at the negedge after edge k
  localparam int DtNever = 2;  // no acknowledge at all

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m68k_bus_initiator_if bus ();

  m68k_bus_initiator #(
    .TIMEOUT (Timeout),
    .CNT_W   (8)
  ) dut (
    .i_CLK     (clk),
    .i_RESET_n (rst_n),
    .bus       (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] rdata_model = 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request; the model derives every timing from the state sequence and the
  // two-clock acknowledge synchroniser, then compares against what was observed.
  task automatic run_txn(input logic [23:0] addr, input logic wr, input logic byte_acc,
                         input logic [15:0] wdata, input logic [15:0] rd, input int mode,
                         input int k, input bit hold, input string tag);
    bit   mis, dt;
    int   w, exp_r, exp_ready;
    logic exp_err, exp_uds, exp_lds;
    int   rsp_e = -1, ready_e = -1, as_e = -1, ds_e = -1, n_valid = 0;
    int   ds_bad = 0, lane_bad = 0, hold_bad = 0, idle_as_bad = 0;
    logic got_err = 1'b0, rw_rel = 1'b0, rw_rdy = 1'b0, oe_rdy = 1'b1;
    logic [15:0] got_rdata = 16'h0000;

    mis     = !byte_acc && addr[0];
    exp_uds = byte_acc ? !addr[0] : 1'b1;
    exp_lds = byte_acc ?  addr[0] : 1'b1;
    w       = wr ? 3 : 2;
    if (mis) begin
      exp_r = 0; exp_err = 1'b1; dt = (mode == DtPre);
    end else if (mode == DtPre) begin
      exp_r = w + 1; exp_err = 1'b0; dt = 1'b1;
    end else if (mode == DtDelay) begin
      exp_r = (k + 3 > w + 1) ? k + 3 : w + 1; exp_err = 1'b0; dt = 1'b1;
    end else begin
      exp_r = w + int'(Timeout); exp_err = 1'b1; dt = 1'b0;
    end
    exp_ready = !dt ? exp_r + 2 : (hold ? exp_r + 1 + int'(Timeout) : exp_r + 3);
    if (!exp_err && !wr) rdata_model = rd;

    @(negedge clk);
    bus.i_D       = rd;
    bus.i_DTACK_n = (mode == DtPre) ? 1'b0 : 1'b1;
    check_eq({tag, "_ready"}, 32'(bus.o_REQ_READY), 32'd1);
    bus.i_REQ       = 1'b1;
    bus.i_REQ_ADDR  = addr;
    bus.i_REQ_WR    = wr;
    bus.i_REQ_BYTE  = byte_acc;
    bus.i_REQ_WDATA = wdata;
    @(posedge clk);
    for (int e = 0; e < 150 && ready_e < 0; e++) begin
      @(negedge clk);
      if (e == 0) begin
        bus.i_REQ = 1'b0;
        if (!mis) begin
          check_eq({tag, "_addr"}, 32'(bus.o_A), 32'(addr[23:1]));
          check_eq({tag, "_rw"}, 32'(bus.o_RW), 32'(!wr));
          check_eq({tag, "_doe"}, 32'(bus.o_D_OE), 32'(wr));
          if (wr) check_eq({tag, "_d"}, 32'(bus.o_D), 32'(wdata));
        end
      end
      // Request inputs must be ignored outside IDLE.
      bus.i_REQ_ADDR  = 24'($urandom);
      bus.i_REQ_WDATA = 16'($urandom);
      bus.i_REQ_WR    = 1'($urandom);
      bus.i_REQ_BYTE  = 1'($urandom);
      if (!bus.o_AS_n && as_e < 0) as_e = e;
      if ((!bus.o_UDS_n || !bus.o_LDS_n) && ds_e < 0) ds_e = e;
      if (bus.o_AS_n && (!bus.o_UDS_n || !bus.o_LDS_n)) ds_bad++;
      if ((!bus.o_UDS_n || !bus.o_LDS_n) &&
          ({!bus.o_UDS_n, !bus.o_LDS_n} != {exp_uds, exp_lds})) lane_bad++;
      if (!bus.o_AS_n && (bus.o_A != addr[23:1] || bus.o_RW != !wr ||
          (wr && (bus.o_D != wdata || !bus.o_D_OE)) || (!wr && bus.o_D_OE))) hold_bad++;
      if (bus.o_REQ_READY && !bus.o_AS_n) idle_as_bad++;
      if (bus.o_RSP_VALID) begin
        n_valid++;
        if (rsp_e < 0) begin
          rsp_e     = e;
          got_err   = bus.o_RSP_ERR;
          got_rdata = bus.o_RSP_RDATA;
          rw_rel    = bus.o_RW;
          if (!hold) bus.i_DTACK_n = 1'b1;
        end
      end
      if (mode == DtDelay && e == k && rsp_e < 0) bus.i_DTACK_n = 1'b0;
      if (rsp_e >= 0 && bus.o_REQ_READY) begin
        ready_e = e;
        rw_rdy  = bus.o_RW;
        oe_rdy  = bus.o_D_OE;
      end
    end
    bus.i_DTACK_n = 1'b1;

    check_eq({tag, "_rsp_lat"}, 32'(rsp_e), 32'(exp_r));
    check_eq({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check_eq({tag, "_rdata"}, 32'(got_rdata), 32'(rdata_model));
    check_eq({tag, "_nvalid"}, 32'(n_valid), 32'd1);
    check_eq({tag, "_ready_lat"}, 32'(ready_e), 32'(exp_ready));
    check_eq({tag, "_as_first"}, 32'(as_e), mis ? 32'hFFFF_FFFF : 32'd1);
    check_eq({tag, "_ds_first"}, 32'(ds_e), mis ? 32'hFFFF_FFFF : (wr ? 32'd2 : 32'd1));
    check_eq({tag, "_ds_wo_as"}, 32'(ds_bad), 32'd0);
    check_eq({tag, "_lanes"}, 32'(lane_bad), 32'd0);
    check_eq({tag, "_held"}, 32'(hold_bad), 32'd0);
    check_eq({tag, "_as_idle"}, 32'(idle_as_bad), 32'd0);
    if (!mis) check_eq({tag, "_rw_rel"}, 32'(rw_rel), 32'(!wr));
    check_eq({tag, "_rw_idle"}, 32'(rw_rdy), 32'd1);
    check_eq({tag, "_oe_idle"}, 32'(oe_rdy), 32'd0);
  endtask

  initial begin
    int n_valid_rst;
    bus.i_REQ       = 1'b0;
    bus.i_REQ_ADDR  = '0;
    bus.i_REQ_WR    = 1'b0;
    bus.i_REQ_BYTE  = 1'b0;
    bus.i_REQ_WDATA = '0;
    bus.i_D         = '0;
    bus.i_DTACK_n   = 1'b1;

    #12;
    check_eq("rst_as", 32'(bus.o_AS_n), 32'd1);
    check_eq("rst_ds", 32'({bus.o_UDS_n, bus.o_LDS_n}), 32'd3);
    check_eq("rst_rw", 32'(bus.o_RW), 32'd1);
    check_eq("rst_doe", 32'(bus.o_D_OE), 32'd0);
    check_eq("rst_a", 32'(bus.o_A), 32'd0);
    check_eq("rst_d", 32'(bus.o_D), 32'd0);
    check_eq("rst_rsp", 32'({bus.o_RSP_VALID, bus.o_RSP_ERR}), 32'd0);
    check_eq("rst_rdata", 32'(bus.o_RSP_RDATA), 32'd0);
    check_eq("rst_ready", 32'(bus.o_REQ_READY), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(24'h000100, 1'b0, 1'b0, 16'h0000, 16'hBEEF, DtPre,   0, 1'b0, "t1_word_rd");
    run_txn(24'h000101, 1'b1, 1'b1, 16'h0055, 16'h1234, DtPre,   0, 1'b0, "t2_byte_wr");
    run_txn(24'h000200, 1'b0, 1'b0, 16'h0000, 16'hDEAD, DtNever, 0, 1'b0, "t3_timeout");
    run_txn(24'h000003, 1'b0, 1'b0, 16'h0000, 16'h5555, DtNever, 0, 1'b0, "t4_misalign");
    run_txn(24'h000400, 1'b0, 1'b1, 16'h0000, 16'hA5C3, DtPre,   0, 1'b1, "t5_stuck");
    run_txn(24'h000402, 1'b0, 1'b0, 16'h0000, 16'h0F0F, DtDelay, 5, 1'b0, "t5_next");

    for (int i = 0; i < 30; i++) begin
      run_txn(24'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 12)),
              ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a WAIT that would otherwise time out.
    @(negedge clk);
    bus.i_DTACK_n  = 1'b1;
    bus.i_REQ      = 1'b1;
    bus.i_REQ_ADDR = 24'h000800;
    bus.i_REQ_WR   = 1'b0;
    bus.i_REQ_BYTE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.i_REQ = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t6_as_before", 32'(bus.o_AS_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_as", 32'(bus.o_AS_n), 32'd1);
    check_eq("t6_ds", 32'({bus.o_UDS_n, bus.o_LDS_n}), 32'd3);
    check_eq("t6_valid", 32'(bus.o_RSP_VALID), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdata_model = 16'h0000;
    n_valid_rst = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_RSP_VALID) n_valid_rst++;
    end
    check_eq("t6_no_rsp", 32'(n_valid_rst), 32'd0);
    check_eq("t6_ready", 32'(bus.o_REQ_READY), 32'd1);
    run_txn(24'h000810, 1'b0, 1'b0, 16'h0000, 16'h7777, DtNever, 0, 1'b0, "t6_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
